// File: rtl/corr_peak_detector_if.sv
// ----------------------------------------------------------------------------
// corr_peak_detector_if
//
// Bundles the sample stream coming from the correlator and the detection
// results going downstream.
//
//   master (correlator side / driver)
//      data       out  WIDTH   correlation sample, qualified by valid
//      valid      out  1       one-cycle load strobe per new sample
//      clear      out  1       synchronous abort of any window or hold-off
//      peak       in   WIDTH   maximum of the last reported window
//      peakIndex  in   IDXW    offset of peak inside its window
//      peakValid  in   1       one-cycle pulse when a report is issued
//      busy       in   1       detector is searching or holding off
//      detCount   in   8       saturating number of reports since reset
//
//   slave (detector side) sees the same signals with directions reversed.
// ----------------------------------------------------------------------------
interface corr_peak_detector_if #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned WIN   = 8
);

    localparam int unsigned IDXW = (WIN > 1) ? $clog2(WIN) : 1;

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             clear;
    logic [WIDTH-1:0] peak;
    logic [IDXW-1:0]  peakIndex;
    logic             peakValid;
    logic             busy;
    logic [7:0]       detCount;

    modport master (
        output data,
        output valid,
        output clear,
        input  peak,
        input  peakIndex,
        input  peakValid,
        input  busy,
        input  detCount
    );

    modport slave (
        input  data,
        input  valid,
        input  clear,
        output peak,
        output peakIndex,
        output peakValid,
        output busy,
        output detCount
    );

endinterface

// File: rtl/corr_peak_detector.sv
// ----------------------------------------------------------------------------
// corr_peak_detector
//
// Watches the correlator output for a sample at or above THRESHOLD. The
// crossing sample opens a window of WIN strobed samples in which the maximum
// and its offset are tracked. When the window closes the peak is reported
// with a one-cycle pulse, and the next HOLDOFF strobed samples are ignored so
// that one sync pattern yields exactly one detection.
//
// Parameters
//   WIDTH      sample width
//   THRESHOLD  crossing level (sample >= THRESHOLD opens a window)
//   WIN        samples per search window, crossing sample included (>= 2)
//   HOLDOFF    strobed samples discarded after each report (0 allowed)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        slave side of corr_peak_detector_if
//                data/valid/clear in, peak/peakIndex/peakValid/busy/detCount out
// ----------------------------------------------------------------------------
module corr_peak_detector #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned THRESHOLD = 600,
    parameter int unsigned WIN       = 8,
    parameter int unsigned HOLDOFF   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    corr_peak_detector_if.slave bus
);

    localparam int unsigned IDXW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned WCW  = $clog2(WIN + 1);
    localparam int unsigned HCW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [WIDTH-1:0] THRESH    = WIDTH'(THRESHOLD);
    localparam logic [WCW-1:0]   WIN_LAST  = WCW'(WIN);
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] max_q;
    logic [IDXW-1:0]  idx_q;
    logic [WCW-1:0]   winCnt_q;
    logic [HCW-1:0]   holdCnt_q;
    logic [WIDTH-1:0] peak_q;
    logic [IDXW-1:0]  peakIdx_q;
    logic             peakValid_q;
    logic             busy_q;
    logic [7:0]       detCount_q;

    logic             crossing;
    logic             newMax;
    logic             windowDone;
    logic             holdDone;
    logic [WCW-1:0]   winCnt_d;
    logic [HCW-1:0]   holdCnt_d;
    logic [WIDTH-1:0] max_d;
    logic [IDXW-1:0]  idx_d;

    // Per-sample decisions. max_d/idx_d fold the current strobed sample into
    // the running maximum so the closing sample of a window can still win the
    // report. A strict compare keeps the earliest index on ties.
    always_comb begin
        crossing   = bus.valid && (bus.data >= THRESH);
        newMax     = bus.data > max_q;
        winCnt_d   = winCnt_q + 1'b1;
        holdCnt_d  = holdCnt_q + 1'b1;
        windowDone = (winCnt_d == WIN_LAST);
        holdDone   = (holdCnt_d == HOLD_LAST);
        max_d      = newMax ? bus.data : max_q;
        idx_d      = newMax ? winCnt_q[IDXW-1:0] : idx_q;
    end

    // Detector FSM with all outputs registered. Clear has priority over any
    // sample in the same cycle and wipes only the in-progress search state;
    // the last report and the detection count are deliberately kept.
    // Busy stays high through the report cycle so it falls only after the
    // Peak_Valid pulse, even when there is no hold-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            winCnt_q    <= '0;
            holdCnt_q   <= '0;
            peak_q      <= '0;
            peakIdx_q   <= '0;
            peakValid_q <= 1'b0;
            busy_q      <= 1'b0;
            detCount_q  <= '0;
        end else begin
            peakValid_q <= 1'b0;
            if (bus.clear) begin
                state_q   <= IDLE;
                max_q     <= '0;
                idx_q     <= '0;
                winCnt_q  <= '0;
                holdCnt_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        busy_q <= crossing;
                        if (crossing) begin
                            state_q  <= SEARCH;
                            max_q    <= bus.data;
                            idx_q    <= '0;
                            winCnt_q <= WCW'(1);
                        end
                    end

                    SEARCH: begin
                        busy_q <= 1'b1;
                        if (bus.valid) begin
                            max_q    <= max_d;
                            idx_q    <= idx_d;
                            winCnt_q <= winCnt_d;
                            if (windowDone) begin
                                peak_q      <= max_d;
                                peakIdx_q   <= idx_d;
                                peakValid_q <= 1'b1;
                                if (detCount_q != 8'hFF) begin
                                    detCount_q <= detCount_q + 8'd1;
                                end
                                max_q     <= '0;
                                idx_q     <= '0;
                                winCnt_q  <= '0;
                                holdCnt_q <= '0;
                                if (HOLDOFF == 0) begin
                                    state_q <= IDLE;
                                end else begin
                                    state_q <= HOLD;
                                end
                            end
                        end
                    end

                    HOLD: begin
                        busy_q <= 1'b1;
                        if (bus.valid) begin
                            holdCnt_q <= holdCnt_d;
                            if (holdDone) begin
                                state_q   <= IDLE;
                                holdCnt_q <= '0;
                                busy_q    <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.peak      = peak_q;
    assign bus.peakIndex = peakIdx_q;
    assign bus.peakValid = peakValid_q;
    assign bus.busy      = busy_q;
    assign bus.detCount  = detCount_q;

endmodule

// File: tb/tb_corr_peak_detector.sv
// ----------------------------------------------------------------------------
// tb_corr_peak_detector
//
// Two detectors share one clock: dutA uses the default hold-off of 16 and
// covers detection, ties, gaps, hold-off and the abort paths; dutB uses a
// hold-off of 0 and runs 300 back-to-back windows to exercise saturation.
// Expected reports are queued when the window is driven and popped by a
// monitor whenever the matching detector pulses Peak_Valid.
// ----------------------------------------------------------------------------
module tb_corr_peak_detector;

    logic clk;
    logic rst_n;

    corr_peak_detector_if #(.WIDTH(11), .WIN(8)) ifA ();
    corr_peak_detector_if #(.WIDTH(11), .WIN(8)) ifB ();

    corr_peak_detector #(
        .WIDTH(11), .THRESHOLD(600), .WIN(8), .HOLDOFF(16)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    corr_peak_detector #(
        .WIDTH(11), .THRESHOLD(600), .WIN(8), .HOLDOFF(0)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    typedef struct {
        int gap;
        int n;
        int samples [12];
        int expPeak;
        int expIdx;
    } vec_t;

    typedef struct {
        int peak;
        int idx;
        int det;
    } exp_t;

    vec_t vecs [4];
    exp_t expA [$];
    exp_t expB [$];

    int nChecks = 0;
    int nFails  = 0;
    int expDet  = 0;
    int pulsesB = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One strobed sample on dutA, optionally with a simultaneous Clear.
    task automatic applyStimulus(input int data, input bit clr);
        ifA.data  = 11'(data);
        ifA.valid = 1'b1;
        ifA.clear = clr;
        @(posedge clk);
        #1;
        ifA.valid = 1'b0;
        ifA.clear = 1'b0;
    endtask

    task automatic applyB(input int data);
        ifB.data  = 11'(data);
        ifB.valid = 1'b1;
        @(posedge clk);
        #1;
        ifB.valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard for dutA: every pulse must match the oldest queued report.
    always @(negedge clk) begin
        if (ifA.peakValid === 1'b1) begin
            if (expA.size() == 0) begin
                checkOutput("A_unexpected_peak_valid", 32'(ifA.peakValid), 32'd0);
            end else begin
                exp_t e;
                e = expA.pop_front();
                checkOutput("A_peak", 32'(ifA.peak), 32'(e.peak));
                checkOutput("A_peak_index", 32'(ifA.peakIndex), 32'(e.idx));
                checkOutput("A_det_count", 32'(ifA.detCount), 32'(e.det));
            end
        end
    end

    // Scoreboard for dutB, also counting pulses for the saturation check.
    always @(negedge clk) begin
        if (ifB.peakValid === 1'b1) begin
            pulsesB++;
            if (expB.size() == 0) begin
                checkOutput("B_unexpected_peak_valid", 32'(ifB.peakValid), 32'd0);
            end else begin
                exp_t e;
                e = expB.pop_front();
                checkOutput("B_peak", 32'(ifB.peak), 32'(e.peak));
                checkOutput("B_peak_index", 32'(ifB.peakIndex), 32'(e.idx));
                checkOutput("B_det_count", 32'(ifB.detCount), 32'(e.det));
            end
        end
    end

    initial begin
        // Window vectors: leading sub-threshold samples are part of the list.
        vecs[0].gap = 0; vecs[0].n = 9;
        vecs[0].samples = '{100, 650, 700, 900, 880, 500, 400, 300, 200, 0, 0, 0};
        vecs[0].expPeak = 900; vecs[0].expIdx = 2;

        vecs[1].gap = 2; vecs[1].n = 8;
        vecs[1].samples = '{650, 800, 800, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].expPeak = 800; vecs[1].expIdx = 1;

        vecs[2].gap = 1; vecs[2].n = 9;
        vecs[2].samples = '{599, 600, 10, 20, 30, 40, 50, 60, 70, 0, 0, 0};
        vecs[2].expPeak = 600; vecs[2].expIdx = 0;

        vecs[3].gap = 0; vecs[3].n = 8;
        vecs[3].samples = '{700, 701, 702, 703, 704, 705, 706, 2047, 0, 0, 0, 0};
        vecs[3].expPeak = 2047; vecs[3].expIdx = 7;

        rst_n     = 1'b0;
        ifA.data  = '0; ifA.valid = 1'b0; ifA.clear = 1'b0;
        ifB.data  = '0; ifB.valid = 1'b0; ifB.clear = 1'b0;

        // Reset held with random activity: outputs must stay at zero.
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            ifA.data  = 11'($urandom_range(0, 2047));
            ifA.valid = 1'($urandom_range(0, 1));
            ifA.clear = 1'($urandom_range(0, 1));
            ifB.data  = 11'($urandom_range(0, 2047));
            ifB.valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("reset_peak", 32'(ifA.peak), 32'd0);
            checkOutput("reset_peak_index", 32'(ifA.peakIndex), 32'd0);
            checkOutput("reset_peak_valid", 32'(ifA.peakValid), 32'd0);
            checkOutput("reset_busy", 32'(ifA.busy), 32'd0);
            checkOutput("reset_det_count", 32'(ifA.detCount), 32'd0);
            checkOutput("reset_B_busy", 32'(ifB.busy), 32'd0);
        end
        ifA.valid = 1'b0; ifA.clear = 1'b0; ifB.valid = 1'b0;
        rst_n = 1'b1;
        idleCycles(1);

        // Sub-threshold samples never open a window.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($urandom_range(0, 599), 1'b0);
            checkOutput("below_threshold_busy", 32'(ifA.busy), 32'd0);
        end

        // Table-driven windows, each followed by a full hold-off of 1000s.
        for (int v = 0; v < 4; v++) begin
            expDet++;
            expA.push_back('{vecs[v].expPeak, vecs[v].expIdx, expDet});
            for (int k = 0; k < vecs[v].n; k++) begin
                applyStimulus(vecs[v].samples[k], 1'b0);
                if (k != vecs[v].n - 1) idleCycles(vecs[v].gap);
            end
            checkOutput("report_latency", 32'(ifA.peakValid), 32'd1);
            checkOutput("det_count_with_pulse", 32'(ifA.detCount), 32'(expDet));
            idleCycles(1);
            checkOutput("report_one_cycle", 32'(ifA.peakValid), 32'd0);
            checkOutput("busy_in_hold", 32'(ifA.busy), 32'd1);
            for (int k = 0; k < 16; k++) begin
                applyStimulus(1000, 1'b0);
                if (k == 14) checkOutput("busy_before_last_hold", 32'(ifA.busy), 32'd1);
            end
            checkOutput("holdoff_end_idle", 32'(ifA.busy), 32'd0);
        end

        // The 17th 1000 after a report opens a new window.
        expDet++;
        expA.push_back('{1500, 5, expDet});
        applyStimulus(1000, 1'b0);
        checkOutput("busy_rises_after_crossing", 32'(ifA.busy), 32'd1);
        applyStimulus(1000, 1'b0);
        applyStimulus(1000, 1'b0);
        applyStimulus(1000, 1'b0);
        applyStimulus(1000, 1'b0);
        applyStimulus(1500, 1'b0);
        applyStimulus(1000, 1'b0);
        applyStimulus(1000, 1'b0);
        checkOutput("holdoff_window_report", 32'(ifA.peakValid), 32'd1);
        idleCycles(1);

        // Clear during HOLD returns straight to IDLE.
        applyStimulus(1000, 1'b1);
        checkOutput("clear_in_hold_busy", 32'(ifA.busy), 32'd0);

        // Clear mid-SEARCH with a concurrent 1000: window dropped, report kept.
        applyStimulus(650, 1'b0);
        applyStimulus(700, 1'b0);
        applyStimulus(750, 1'b0);
        applyStimulus(800, 1'b0);
        checkOutput("search_busy", 32'(ifA.busy), 32'd1);
        applyStimulus(1000, 1'b1);
        checkOutput("clear_busy", 32'(ifA.busy), 32'd0);
        checkOutput("clear_peak_valid", 32'(ifA.peakValid), 32'd0);
        checkOutput("clear_keeps_peak", 32'(ifA.peak), 32'd1500);
        checkOutput("clear_keeps_index", 32'(ifA.peakIndex), 32'd5);
        checkOutput("clear_keeps_det", 32'(ifA.detCount), 32'(expDet));
        for (int k = 0; k < 4; k++) applyStimulus(300, 1'b0);
        checkOutput("after_clear_idle", 32'(ifA.busy), 32'd0);

        // Reset mid-SEARCH: immediate zeroing, no report afterwards.
        applyStimulus(610, 1'b0);
        applyStimulus(620, 1'b0);
        applyStimulus(630, 1'b0);
        applyStimulus(640, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_peak", 32'(ifA.peak), 32'd0);
        checkOutput("async_reset_index", 32'(ifA.peakIndex), 32'd0);
        checkOutput("async_reset_busy", 32'(ifA.busy), 32'd0);
        checkOutput("async_reset_det", 32'(ifA.detCount), 32'd0);
        idleCycles(2);
        rst_n = 1'b1;
        expDet = 0;
        for (int k = 0; k < 4; k++) applyStimulus(300, 1'b0);
        checkOutput("after_reset_idle", 32'(ifA.busy), 32'd0);

        // Count restarts from zero after reset.
        expDet++;
        expA.push_back('{607, 7, expDet});
        for (int k = 0; k < 8; k++) applyStimulus(600 + k, 1'b0);
        checkOutput("post_reset_report", 32'(ifA.peakValid), 32'd1);
        idleCycles(2);

        // 300 back-to-back windows on the zero hold-off detector.
        for (int w = 0; w < 300; w++) begin
            expB.push_back('{601 + w, w % 8, (w + 1 > 255) ? 255 : w + 1});
            for (int k = 0; k < 8; k++) begin
                applyB((k == w % 8) ? 601 + w : 600);
            end
        end
        idleCycles(3);

        checkOutput("B_pulse_count", 32'(pulsesB), 32'd300);
        checkOutput("B_det_saturated", 32'(ifB.detCount), 32'd255);
        checkOutput("B_idle_at_end", 32'(ifB.busy), 32'd0);
        checkOutput("A_reports_outstanding", 32'(expA.size()), 32'd0);
        checkOutput("B_reports_outstanding", 32'(expB.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
